load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, checks alignment,
// size and range, performs byte/half/word loads with extension, and does
// read-modify-write for sub-word stores against a single-port word memory.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] w_word_idx;
  logic        w_req_err;

  // Little-endian extraction of the addressed byte/half with sign/zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replaces only the addressed byte/half of the read word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          2'd3:    res[31:24] = wd[7:0];
          default: res = word;
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      2'b10:   res = wd;
      default: res = word;
    endcase
    return res;
  endfunction

  assign w_word_idx = {2'b00, req_addr[31:2]};

  // Request legality: illegal size, misalignment, or word index past the memory.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
    if (w_word_idx >= MEM_WORDS) begin
      w_req_err = 1'b1;
    end else begin
      w_req_err = w_req_err;
    end
  end

  // Next-state logic; word stores skip the read, sub-word stores read first.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_next_state = RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = READ;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      READ:    w_next_state = r_we ? WRITE : RESP;
      WRITE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latching at accept, then load result or merged store word at the end of READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= 32'h0000_0000;
      r_lane      <= 2'b00;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_we        <= 1'b0;
      r_wdata     <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_rdata     <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= w_word_idx;
            r_lane      <= req_addr[1:0];
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_we        <= req_we;
            r_wdata     <= req_wdata;
            r_mem_wdata <= req_wdata;
            r_rdata     <= 32'h0000_0000;
            r_err       <= w_req_err;
          end
        end
        READ: begin
          if (r_we) begin
            r_mem_wdata <= store_merge(mem_rdata, r_wdata, r_lane, r_size);
          end else begin
            r_rdata <= load_extract(mem_rdata, r_lane, r_size, r_unsigned);
          end
        end
        default: begin
          r_rdata <= r_rdata;
        end
      endcase
    end
  end

  // Enables and handshakes decode from state; reset blanks them within the same cycle.
  assign req_ready  = (r_state == IDLE)  && !reset;
  assign mem_rd_en  = (r_state == READ)  && !reset;
  assign mem_wr_en  = (r_state == WRITE) && !reset;
  assign resp_valid = (r_state == RESP)  && !reset;
  assign resp_err   = r_err;
  assign resp_rdata = r_rdata;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [0:NV-1];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(32'd1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Combinational read, write commits on negedge.
  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0000_0000;
  always @(negedge clk) begin
    if (mem_wr_en && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wdata;
  end

  // Read and write enables must never overlap.
  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) begin
      n_miss++;
      $display("FAIL rd_wr_overlap: got rd=1 wr=1 expected not both");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input logic err,
                              input logic [31:0] rd, input int lat, input int nrd,
                              input int nwr, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.exp_err = err; v.exp_rdata = rd; v.exp_lat = lat; v.exp_rd = nrd;
    v.exp_wr = nwr; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc;
    logic [31:0] wd, rdat;
    logic err;
    lat = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0;
    wd = 32'h0; rdat = 32'h0; err = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        rd_cnt++; rd_cyc = k;
        chk($sformatf("v%0d rd_addr", idx), mem_addr, v.addr >> 2);
      end
      if (mem_wr_en) begin
        wr_cnt++; wr_cyc = k; wd = mem_wdata;
        chk($sformatf("v%0d wr_addr", idx), mem_addr, v.addr >> 2);
      end
      if (resp_valid) begin
        lat = k; err = resp_err; rdat = resp_rdata;
        break;
      end
    end
    n_vec++;
    if (lat == 0) begin
      n_miss++;
      $display("FAIL v%0d timeout: got no resp_valid expected at N+%0d", idx, v.exp_lat);
    end else begin
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d rdata", idx), rdat, v.exp_rdata);
      chk($sformatf("v%0d rd_count", idx), rd_cnt, v.exp_rd);
      chk($sformatf("v%0d wr_count", idx), wr_cnt, v.exp_wr);
      if (v.exp_rd != 0) chk($sformatf("v%0d rd_cycle", idx), rd_cyc, 32'd1);
      if (v.exp_wr != 0) begin
        chk($sformatf("v%0d wdata", idx), wd, v.exp_wdata);
        chk($sformatf("v%0d wr_cycle", idx), wr_cyc, v.exp_lat - 1);
      end
    end
  endtask

  initial begin
    int acc_n, acc2, resp1, resp2;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[3] = 32'h80FF_7F01;
    mem[5] = 32'h1122_3344;

    //          we    sz     uns   addr          wdata          err   rdata          lat rd wr wdata
    vt[0]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0,        1'b0, 32'h0000_007F, 2, 1, 0, 32'h0);
    vt[1]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_000E, 32'h0,        1'b0, 32'hFFFF_FFFF, 2, 1, 0, 32'h0);
    vt[2]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_000E, 32'h0,        1'b0, 32'h0000_00FF, 2, 1, 0, 32'h0);
    vt[3]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'h0,        1'b0, 32'hFFFF_80FF, 2, 1, 0, 32'h0);
    vt[4]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_000E, 32'h0,        1'b0, 32'h0000_80FF, 2, 1, 0, 32'h0);
    vt[5]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 32'h0000_7F01, 2, 1, 0, 32'h0);
    vt[6]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'h0,        1'b0, 32'hFFFF_FF80, 2, 1, 0, 32'h0);
    vt[7]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 32'h80FF_7F01, 2, 1, 0, 32'h0);
    vt[8]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_00AB, 1'b0, 32'h0,        3, 1, 1, 32'h80FF_AB01);
    vt[9]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 32'h80FF_AB01, 2, 1, 0, 32'h0);
    vt[10] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEAD_BEEF);
    vt[11] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD_BEEF, 2, 1, 0, 32'h0);
    vt[12] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_1234, 1'b0, 32'h0,        3, 1, 1, 32'h1234_BEEF);
    vt[13] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'hCCCC_CC5A, 1'b0, 32'h0,        3, 1, 1, 32'h5A34_BEEF);
    vt[14] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h0000_A5A5, 1'b0, 32'h0,        3, 1, 1, 32'h5A34_A5A5);
    vt[15] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'h5A34_A5A5, 2, 1, 0, 32'h0);
    vt[16] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1'b0, 32'hFFFF_FFA5, 2, 1, 0, 32'h0);
    vt[17] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1'b0, 32'h0000_5A34, 2, 1, 0, 32'h0);
    vt[18] = mk(1'b0, 2'b01, 1'b0, 32'h0000_000D, 32'h0,        1'b1, 32'h0,         1, 0, 0, 32'h0);
    vt[19] = mk(1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'h0,        1'b1, 32'h0,         1, 0, 0, 32'h0);
    vt[20] = mk(1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'h0,        1'b1, 32'h0,         1, 0, 0, 32'h0);
    vt[21] = mk(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'h0,         1, 0, 0, 32'h0);
    vt[22] = mk(1'b1, 2'b10, 1'b0, 32'h0000_000E, 32'h1234_5678, 1'b1, 32'h0,        1, 0, 0, 32'h0);
    vt[23] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_7777, 1'b1, 32'h0,        1, 0, 0, 32'h0);
    vt[24] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,        1'b0, 32'h0,         2, 1, 0, 32'h0);
    vt[25] = mk(1'b1, 2'b00, 1'b0, 32'h0000_1000, 32'h0000_0066, 1'b1, 32'h0,        1, 0, 0, 32'h0);
    vt[26] = mk(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 32'h80FF_AB01, 2, 1, 0, 32'h0);

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_vec++;
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst release ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

    // Reset asserted while an SB is in WRITE: no write, no response.
    n_vec++;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0014; req_wdata = 32'h0000_0099;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstw read_phase", {31'd0, mem_rd_en}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstw wr_en", {31'd0, mem_wr_en}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw ready_after", {31'd0, req_ready}, 32'd1);
    chk("rstw resp_valid", {31'd0, resp_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstw late_resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("rstw mem_word", mem[5], 32'h1122_3344);

    // req_valid held high through a load: one accept, next one after RESP.
    n_vec++;
    acc_n = 0; acc2 = -1; resp1 = -1; resp2 = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_000C; req_wdata = 32'h0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        acc_n++;
        if (acc_n == 2) acc2 = c;
      end
      if (resp_valid) begin
        if (resp1 < 0) resp1 = c;
        else if (resp2 < 0) resp2 = c;
        chk("hold rdata", resp_rdata, 32'h80FF_AB01);
      end
      @(posedge clk); #1;
      if (c == 3) req_valid = 1'b0;
    end
    chk("hold accepts", acc_n, 32'd2);
    chk("hold accept2_cycle", acc2, 32'd3);
    chk("hold resp1_cycle", resp1, 32'd2);
    chk("hold resp2_cycle", resp2, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
